// File: rtl/memory_dumper_pkg.sv
// Shared constants for the program-memory upload/readback paths:
// default widths and the dumper state encoding.
package memory_dumper_pkg;

  localparam int UART_DATA_LENGTH_DEF     = 8;
  localparam int REGISTER_WIDTH_DEF       = 4;
  localparam int MEMORY_ADDRESS_WIDTH_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t stIDLE  = 3'd0;
  localparam state_t stRD_HI = 3'd1;
  localparam state_t stRD_LO = 3'd2;
  localparam state_t stLATCH = 3'd3;
  localparam state_t stSEND  = 3'd4;
  localparam state_t stHOLD  = 3'd5;

  // Number of bytes produced by one full dump of a 2^aw word memory.
  function automatic int dump_bytes(input int aw);
    return 1 << (aw - 1);
  endfunction

endpackage

// File: rtl/memory_dumper.sv
// Program-memory readback: reads word pairs in ascending order, packs them
// (even address -> high nibble) and hands each byte to the UART transmitter.
module memory_dumper
  import memory_dumper_pkg::*;
#(
  parameter int UART_DATA_LENGTH     = UART_DATA_LENGTH_DEF,
  parameter int REGISTER_WIDTH       = REGISTER_WIDTH_DEF,
  parameter int MEMORY_ADDRESS_WIDTH = MEMORY_ADDRESS_WIDTH_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            active_i,
  input  logic                            start_strb_i,
  input  logic [REGISTER_WIDTH-1:0]       data_i,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] addr_o,
  output logic                            enable_read_memory_o,
  output logic [UART_DATA_LENGTH-1:0]     tx_data_o,
  output logic                            tx_start_strb_o,
  input  logic                            tx_busy_i,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_PAIR =
    MEMORY_ADDRESS_WIDTH'((2 ** MEMORY_ADDRESS_WIDTH) - 2);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [MEMORY_ADDRESS_WIDTH-1:0] r_addr;
  logic [UART_DATA_LENGTH-1:0]     r_byte;
  logic                            w_last_pair;

  assign w_last_pair = (r_addr == LAST_PAIR);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= stIDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping active_i aborts from any state; the TX finishes whatever it has.
  always_comb begin
    w_state_next = r_state;
    if (!active_i) begin
      w_state_next = stIDLE;
    end else begin
      case (r_state)
        stIDLE:  if (start_strb_i) w_state_next = stRD_HI;
        stRD_HI: w_state_next = stRD_LO;
        stRD_LO: w_state_next = stLATCH;
        stLATCH: w_state_next = stSEND;
        stSEND:  if (!tx_busy_i) w_state_next = stHOLD;
        stHOLD:  w_state_next = w_last_pair ? stIDLE : stRD_HI;
        default: w_state_next = stIDLE;
      endcase
    end
  end

  always_comb begin
    addr_o               = '0;
    enable_read_memory_o = 1'b0;
    tx_start_strb_o      = 1'b0;
    done_o               = 1'b0;
    case (r_state)
      stRD_HI: begin
        addr_o               = r_addr;
        enable_read_memory_o = 1'b1;
      end
      stRD_LO: begin
        addr_o               = r_addr + MEMORY_ADDRESS_WIDTH'(1);
        enable_read_memory_o = 1'b1;
      end
      stSEND:  tx_start_strb_o = !tx_busy_i;
      stHOLD:  done_o          = w_last_pair;
      default: ;
    endcase
  end

  assign busy_o    = (r_state != stIDLE);
  assign tx_data_o = r_byte;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_addr <= '0;
    end else if (!active_i) begin
      r_addr <= '0;
    end else if (r_state == stIDLE && start_strb_i) begin
      r_addr <= '0;
    end else if (r_state == stHOLD) begin
      r_addr <= r_addr + MEMORY_ADDRESS_WIDTH'(2);
    end
  end

  // Read data lags the address by one cycle, hence the capture one state late.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_byte <= '0;
    end else if (r_state == stRD_LO) begin
      r_byte[UART_DATA_LENGTH-1 -: REGISTER_WIDTH] <= data_i;
    end else if (r_state == stLATCH) begin
      r_byte[REGISTER_WIDTH-1:0] <= data_i;
    end
  end

endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: memory and UART TX models, a
// table of directed dumps, randomized dumps and multi-cycle corner cases.
module tb_memory_dumper;
  import memory_dumper_pkg::*;

  localparam int AW     = 4;
  localparam int RW     = 4;
  localparam int DW     = 8;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = NWORDS / 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          active_i = 1'b0;
  logic          start_strb_i = 1'b0;
  logic          tx_busy_i = 1'b0;
  logic [RW-1:0] data_i = '0;
  logic [AW-1:0] addr_o;
  logic          enable_read_memory_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_start_strb_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  memory_dumper #(
    .UART_DATA_LENGTH    (DW),
    .REGISTER_WIDTH      (RW),
    .MEMORY_ADDRESS_WIDTH(AW)
  ) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .active_i            (active_i),
    .start_strb_i        (start_strb_i),
    .data_i              (data_i),
    .addr_o              (addr_o),
    .enable_read_memory_o(enable_read_memory_o),
    .tx_data_o           (tx_data_o),
    .tx_start_strb_o     (tx_start_strb_o),
    .tx_busy_i           (tx_busy_i),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory with one-cycle registered read.
  logic [RW-1:0] mem [NWORDS];
  always @(posedge clk_i) if (enable_read_memory_o) data_i <= mem[addr_o];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // TX model: busy from the cycle after a strobe for tx_len cycles.
  int tx_len = 1;
  bit force_busy = 1'b0;
  bit strb_pending = 1'b0;
  int busy_left = 0;
  always @(posedge clk_i) begin
    #1;
    if (strb_pending) begin
      busy_left    = tx_len;
      strb_pending = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy_i = force_busy || (busy_left > 0);
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } strb_t;

  strb_t         strb_q[$];
  int            done_cycs[$];
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  int            last_strb_cyc = -10;

  always @(negedge clk_i) begin
    if (reset_i) begin
      if (tx_start_strb_o) begin
        check("strobe_while_busy", 32'(tx_busy_i), 32'd0);
        check("strobe_back_to_back", 32'(cyc == last_strb_cyc + 1), 32'd0);
        last_strb_cyc = cyc;
        strb_q.push_back('{tx_data_o, cyc});
        strb_pending = 1'b1;
      end
      if (done_o) done_cycs.push_back(cyc);
      if (enable_read_memory_o) begin
        check("read_during_send_hold", 32'(tx_start_strb_o || done_o), 32'd0);
        rd_addr_q.push_back(addr_o);
        rd_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    strb_q.delete();
    done_cycs.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NWORDS; i++) begin
      case (kind)
        0:       mem[i] = RW'(i);
        1:       mem[i] = RW'(NWORDS - 1 - i);
        2:       mem[i] = (i % 2 == 0) ? 4'hA : 4'h5;
        default: mem[i] = RW'($urandom_range(0, NWORDS - 1));
      endcase
    end
  endtask

  // Reference: byte j is word 2j in the high nibble, word 2j+1 in the low nibble.
  function automatic logic [DW-1:0] ref_byte(input int j);
    return {mem[2*j], mem[2*j+1]};
  endfunction

  task automatic run_dump(input int extra_off, output int s_cyc);
    clear_mon();
    step();
    start_strb_i = 1'b1;
    s_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      step();
      start_strb_i = (extra_off >= 0) && (cyc == s_cyc + extra_off);
      if (done_cycs.size() > 0) break;
    end
    start_strb_i = 1'b0;
    check("dump_completed", 32'(done_cycs.size() > 0), 32'd1);
    repeat (8) step();
  endtask

  task automatic check_dump(input int s_cyc, input int spacing,
                            input logic [DW-1:0] first, input logic [DW-1:0] last);
    check("byte_count", 32'(strb_q.size()), 32'(NBYTES));
    for (int j = 0; j < strb_q.size() && j < NBYTES; j++) begin
      check("byte_value", 32'(strb_q[j].data), 32'(ref_byte(j)));
      if (j > 0) check("strobe_spacing", 32'(strb_q[j].cyc - strb_q[j-1].cyc), 32'(spacing));
    end
    if (strb_q.size() > 0) begin
      check("first_byte", 32'(strb_q[0].data), 32'(first));
      check("last_byte", 32'(strb_q[strb_q.size()-1].data), 32'(last));
    end
    check("done_count", 32'(done_cycs.size()), 32'd1);
    if (done_cycs.size() > 0 && strb_q.size() > 0)
      check("done_after_last", 32'(done_cycs[0] - strb_q[strb_q.size()-1].cyc), 32'd1);
    check("read_count", 32'(rd_addr_q.size()), 32'(NWORDS));
    for (int k = 0; k < rd_addr_q.size() && k < NWORDS; k++) begin
      check("read_addr", 32'(rd_addr_q[k]), 32'(k));
      if (k % 2 == 1) check("read_pair_adjacent", 32'(rd_cyc_q[k] - rd_cyc_q[k-1]), 32'd1);
    end
    if (rd_cyc_q.size() > 0) check("first_read_latency", 32'(rd_cyc_q[0] - s_cyc), 32'd1);
    check("idle_after_dump", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    int            fill_kind;
    int            tx_len;
    int            extra_start;
    int            spacing;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s_cyc;
    int t1;

    vecs[0] = '{0, 1,  -1, 5,  8'h01, 8'hEF};
    vecs[1] = '{1, 4,  -1, 5,  8'hFE, 8'h10};
    vecs[2] = '{2, 5,  -1, 6,  8'hA5, 8'hA5};
    vecs[3] = '{0, 10, 12, 11, 8'h01, 8'hEF};
    vecs[4] = '{1, 0,  3,  5,  8'hFE, 8'h10};

    // Reset state.
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_strobes", 32'({enable_read_memory_o, tx_start_strb_o, done_o}), 32'd0);
    repeat (3) step();
    reset_i  = 1'b1;
    step();
    check("post_rst_busy", 32'(busy_o), 32'd0);

    // Start while inactive is ignored.
    clear_mon();
    start_strb_i = 1'b1;
    step();
    start_strb_i = 1'b0;
    repeat (6) step();
    check("inactive_no_read", 32'(rd_addr_q.size()), 32'd0);
    check("inactive_not_busy", 32'(busy_o), 32'd0);
    $display("sequence inactive-start: reads=%0d", rd_addr_q.size());

    active_i = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].fill_kind);
      tx_len = vecs[v].tx_len;
      run_dump(vecs[v].extra_start, s_cyc);
      check_dump(s_cyc, vecs[v].spacing, vecs[v].first, vecs[v].last);
      $display("vector %0d: fill=%0d tx_len=%0d bytes=%0d", v, vecs[v].fill_kind, tx_len, strb_q.size());
    end

    for (int r = 0; r < 6; r++) begin
      int sp;
      fill(3);
      tx_len = $urandom_range(0, 12);
      sp = (tx_len + 1 > 5) ? tx_len + 1 : 5;
      run_dump(-1, s_cyc);
      check_dump(s_cyc, sp, ref_byte(0), ref_byte(NBYTES - 1));
      $display("random %0d: tx_len=%0d bytes=%0d", r, tx_len, strb_q.size());
    end

    // Backpressure at the second byte: TX busy 10 cycles after the first strobe.
    fill(0);
    tx_len = 10;
    clear_mon();
    step();
    start_strb_i = 1'b1;
    step();
    start_strb_i = 1'b0;
    for (int i = 0; i < 100 && strb_q.size() < 2; i++) begin
      if (strb_q.size() == 1 && cyc >= strb_q[0].cyc + 5)
        check("bp_data_stable", 32'(tx_data_o), 32'h23);
      step();
    end
    check("bp_second_strobe", 32'(strb_q.size() >= 2), 32'd1);
    if (strb_q.size() >= 2) begin
      check("bp_strobe_cycle", 32'(strb_q[1].cyc - strb_q[0].cyc), 32'd11);
      check("bp_strobe_data", 32'(strb_q[1].data), 32'h23);
    end
    for (int i = 0; i < 200 && done_cycs.size() == 0; i++) step();
    repeat (4) step();
    check("bp_byte_count", 32'(strb_q.size()), 32'(NBYTES));
    $display("sequence backpressure: bytes=%0d", strb_q.size());

    // Abort after the third strobe, then restart from address 0.
    tx_len = 1;
    clear_mon();
    step();
    start_strb_i = 1'b1;
    step();
    start_strb_i = 1'b0;
    for (int i = 0; i < 100 && strb_q.size() < 3; i++) step();
    step();
    active_i = 1'b0;
    repeat (20) step();
    check("abort_strobes", 32'(strb_q.size()), 32'd3);
    check("abort_no_done", 32'(done_cycs.size()), 32'd0);
    check("abort_idle", 32'(busy_o), 32'd0);
    $display("sequence abort: bytes=%0d", strb_q.size());
    active_i = 1'b1;
    step();
    run_dump(-1, s_cyc);
    check_dump(s_cyc, 5, 8'h01, 8'hEF);
    $display("sequence restart: bytes=%0d", strb_q.size());

    // Asynchronous reset while stalled in SEND.
    force_busy = 1'b1;
    repeat (2) step();
    clear_mon();
    start_strb_i = 1'b1;
    step();
    start_strb_i = 1'b0;
    repeat (6) step();
    check("stall_busy", 32'(busy_o), 32'd1);
    check("stall_data", 32'(tx_data_o), 32'h01);
    check("stall_no_strobe", 32'(strb_q.size()), 32'd0);
    #2;
    reset_i = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_data", 32'(tx_data_o), 32'd0);
    check("async_rst_strobes", 32'({enable_read_memory_o, tx_start_strb_o, done_o}), 32'd0);
    force_busy = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    check("rst_release_busy", 32'(busy_o), 32'd0);
    check("rst_release_addr", 32'(addr_o), 32'd0);
    $display("sequence async-reset: busy=%0d", busy_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_dumper.md
# memory_dumper

Readback path for the program memory: on command, reads every 4-bit memory word in ascending address order, packs consecutive word pairs into bytes and hands them one at a time to the UART transmitter. Byte format is the inverse of the upload path: the even address goes in the high nibble and the odd address in the low nibble. A dump therefore reproduces the original upload byte stream. Sits between the memory read port and the UART TX, and is active only in programming mode.

## Interface
- UART_DATA_LENGTH, 8, TX byte width; must equal 2*REGISTER_WIDTH
- REGISTER_WIDTH, 4, memory word width
- MEMORY_ADDRESS_WIDTH, 4, memory address width (>=1); one dump = 2^(MEMORY_ADDRESS_WIDTH-1) bytes
- clk_i  input  1  single clock, rising edge
- reset_i  input  1  asynchronous, active-low reset
- active_i  input  1  programming mode enable (level)
- start_strb_i  input  1  one-cycle dump request
- data_i  input  REGISTER_WIDTH  memory read data, valid 1 cycle after read enable
- addr_o  output  MEMORY_ADDRESS_WIDTH  memory read address
- enable_read_memory_o  output  1  memory read enable
- tx_data_o  output  UART_DATA_LENGTH  byte to transmit
- tx_start_strb_o  output  1  one-cycle TX start
- tx_busy_i  input  1  TX busy; TX raises it the cycle after tx_start_strb_o
- busy_o  output  1  dump in progress (state != stIDLE)
- done_o  output  1  one-cycle pulse after the last byte is started

## Operation
- Registers: state, addr (MEMORY_ADDRESS_WIDTH bits, even-aligned), byte (UART_DATA_LENGTH bits).
- stIDLE: outputs 0. If start_strb_i && active_i, go to stRD_HI with addr=0. A start while !active_i is ignored.
- stRD_HI: addr_o=addr, enable_read_memory_o=1. Next state stRD_LO.
- stRD_LO: addr_o=addr+1, enable_read_memory_o=1. Capture byte[7:4]<=data_i. Next state stLATCH.
- stLATCH: capture byte[3:0]<=data_i. Next state stSEND.
- stSEND: if !tx_busy_i, pulse tx_start_strb_o=1 and go to stHOLD; otherwise stay.
- stHOLD: guard cycle that lets the TX raise busy. addr<=addr+2, modulo 2^MEMORY_ADDRESS_WIDTH. If the old addr was 2^MEMORY_ADDRESS_WIDTH-2, pulse done_o and go to stIDLE; otherwise go to stRD_HI.
- tx_data_o is driven from the byte register at all times. It is stable from stLATCH+1 until the next stRD_LO.
- start_strb_i while busy_o=1 is ignored.
- active_i low in any state: on the next edge go to stIDLE with addr=0. No further strobes and no done_o. A byte already started is finished by the TX.
- Strobes and memory controls decode combinationally from state. The only input they depend on is tx_busy_i in stSEND.

## Timing
- Reset (reset_i=0): state=stIDLE, addr=0, byte=0. All outputs 0 immediately (asynchronous).
- Memory read latency is 1 cycle.
- Minimum per byte with TX idle: 5 cycles (RD_HI, RD_LO, LATCH, SEND, HOLD).
- First memory read occurs 1 cycle after start_strb_i is sampled.
- tx_start_strb_o is never asserted in a cycle where tx_busy_i=1. It is never asserted on two consecutive cycles.
- done_o coincides with stHOLD of the final byte, 1 cycle after its tx_start_strb_o.
- Simultaneous start_strb_i and !active_i: stay in stIDLE.

## Structure
- Shared package holds the width defaults and the state encoding localparams (stIDLE..stHOLD, 3 bits), shared with the upload path's constants.
- No sub-module: a single FSM with a datapath register.

## Test plan
- Reset: hold reset_i=0 mid-stSEND → all outputs 0 asynchronously. After release, busy_o=0 and addr_o=0.
- Full dump, mem[i]=i, TX idle: tx_data_o at each of the 8 strobes is 0x01, 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF. Strobes are 5 cycles apart. done_o fires once, 1 cycle after the 8th strobe.
- Backpressure: tx_busy_i=1 for 10 cycles at the 2nd byte → no strobe while busy, tx_data_o=0x23 stable. Strobe occurs in the first cycle with tx_busy_i=0.
- Abort: active_i dropped after the 3rd strobe → no more strobes, no done_o, returns to stIDLE. A re-start yields 0x01 as the first byte.
- Ignored starts: start_strb_i with active_i=0 → no read enable. A second start_strb_i mid-dump → sequence unchanged, still exactly 8 bytes.
- Memory wiring: after each stRD_HI/stRD_LO pair, addr_o is 2k then 2k+1 with enable_read_memory_o=1. Read enable is never asserted in stSEND or stHOLD.
